// File: rtl/flip_pkg.sv
// ----------------------------------------------------------------------------
// flip_pkg
// Shared types for the flip-pair scheduler.
//   IDX_W       : bit-index width; the datapath word is 2**IDX_W bits wide
//   WORD_W      : width of the datapath word (and of its shadow copy)
//   flip_idx_t  : one bit index into the datapath word
//   flip_pair_t : two indices issued together as one flip command
// ----------------------------------------------------------------------------
package flip_pkg;

   localparam int IDX_W  = 5;
   localparam int WORD_W = 1 << IDX_W;

   typedef logic [IDX_W-1:0] flip_idx_t;

   typedef struct packed {
      flip_idx_t i;
      flip_idx_t j;
   } flip_pair_t;

endpackage : flip_pkg

// File: rtl/flip_rr_arb.sv
// ----------------------------------------------------------------------------
// flip_rr_arb
// Round-robin arbiter with a rotating priority pointer.
//   clk, rst_n : clock, synchronous active-low reset (pointer returns to 0)
//   req        : request vector, one bit per requester
//   en         : grant enable; with en low no grant is made and the pointer holds
//   gnt        : one-hot grant (all zero when nothing is granted)
//   gnt_idx    : index of the highest-priority requester; meaningful when |gnt
// The search starts at the pointer. After a grant to k the pointer moves to
// (k+1) mod N, so k becomes the lowest priority on the next cycle.
// ----------------------------------------------------------------------------
module flip_rr_arb #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] ptr;
   logic [IW-1:0] ptr_next;
   logic          found;
   int            cand;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr) + k) % N;
         if (!found && req[cand]) begin
            found   = 1'b1;
            gnt_idx = IW'(cand);
         end
      end
      if (found && en) begin
         gnt[gnt_idx] = 1'b1;
      end
   end

   assign ptr_next = IW'((int'(gnt_idx) + 1) % N);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (|gnt) begin
         ptr <= ptr_next;
      end
   end

endmodule : flip_rr_arb

// File: rtl/flip_pair_sched.sv
// ----------------------------------------------------------------------------
// flip_pair_sched
// Collects single-bit flip requests from NREQ requesters, pairs the two oldest
// distinct indices into one command and drives the bit-flip datapath. Because
// flips only ever go out in pairs, the datapath word keeps even parity; a
// shadow copy of the word checks that.
//
// Ports
//   clk, rst_n   : clock, synchronous active-low reset
//   req_valid    : requester k has an index to flip
//   req_idx      : index of requester k at [k*IDX_W +: IDX_W]
//   req_ready    : one-hot grant (combinational)
//   flip_valid   : paired flip command valid (registered)
//   flip_i/j     : the two bits to flip; never equal while flip_valid
//   flip_ready   : datapath accepts the command this cycle
//   pend_count   : pending-index FIFO occupancy
//   cancel_pulse : one-cycle pulse when two equal indices annihilate
//   shadow_q     : mirror of the datapath word
//   parity_err   : sticky, set when the shadow word shows odd parity
//
// Handshake semantics (both interfaces): a transfer happens on a rising clk
// edge where valid and ready are both high. On the request side ready is only
// ever raised toward a requester whose valid is already high. On the command
// side flip_valid, once high, stays high with flip_i/flip_j stable until the
// edge where flip_ready is seen.
// ----------------------------------------------------------------------------
module flip_pair_sched
   import flip_pkg::*;
#(
   parameter  int NREQ       = 4,
   parameter  int FIFO_DEPTH = 4,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int CW         = AW + 1,
   localparam int GW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*IDX_W-1:0] req_idx,
   output logic [NREQ-1:0]       req_ready,
   output logic                  flip_valid,
   output logic [IDX_W-1:0]      flip_i,
   output logic [IDX_W-1:0]      flip_j,
   input  logic                  flip_ready,
   output logic [CW-1:0]         pend_count,
   output logic                  cancel_pulse,
   output logic [WORD_W-1:0]     shadow_q,
   output logic                  parity_err
);

   // ---------------------------------------------------------------------
   // Pending-index FIFO storage and pointers
   // ---------------------------------------------------------------------
   flip_idx_t     mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr_p1;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after_pop;

   flip_idx_t     h0;
   flip_idx_t     h1;
   flip_idx_t     push_idx;

   logic          stage_free;
   logic          do_issue;
   logic          do_cancel;
   logic          pop2;
   logic          space_ok;
   logic          push;
   logic          arb_en;

   logic [NREQ-1:0] gnt;
   logic [GW-1:0]   gnt_idx;

   flip_pair_t      pair_q;
   logic            accept;
   logic [WORD_W-1:0] shadow_next;

   // ---------------------------------------------------------------------
   // Pair stage decision on the two oldest entries
   // ---------------------------------------------------------------------
   assign rd_ptr_p1  = rd_ptr + AW'(1);
   assign h0         = mem[rd_ptr];
   assign h1         = mem[rd_ptr_p1];

   assign stage_free = !flip_valid || flip_ready;
   // Two equal indices cancel regardless of the output stage: flipping one
   // bit twice is a no-op, so they never need to reach the datapath.
   assign do_cancel  = (count >= CW'(2)) && (h0 == h1);
   assign do_issue   = (count >= CW'(2)) && (h0 != h1) && stage_free;
   assign pop2       = do_cancel || do_issue;

   // Space is judged after this cycle's pop, so a full FIFO that is
   // popping two can still take a push in the same cycle.
   assign count_after_pop = count - (pop2 ? CW'(2) : CW'(0));
   assign space_ok        = count_after_pop < CW'(FIFO_DEPTH);

   // ---------------------------------------------------------------------
   // Request arbitration
   // ---------------------------------------------------------------------
   // Gating with rst_n keeps req_ready low while reset is asserted, so no
   // handshake is ever shown that the reset would then discard.
   assign arb_en = space_ok && rst_n;

   flip_rr_arb #(
      .N (NREQ)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = gnt;
   assign push      = |gnt;
   assign push_idx  = req_idx[int'(gnt_idx)*IDX_W +: IDX_W];

   // ---------------------------------------------------------------------
   // FIFO write port (data only; pointers live with the control state)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_idx;
      end
   end

   // ---------------------------------------------------------------------
   // FIFO pointers and occupancy
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop2) begin
            rd_ptr <= rd_ptr + AW'(2);
         end
         count <= count + CW'(push) - (pop2 ? CW'(2) : CW'(0));
      end
   end

   assign pend_count = count;

   // ---------------------------------------------------------------------
   // Output command register and cancel pulse
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flip_valid   <= 1'b0;
         pair_q       <= '0;
         cancel_pulse <= 1'b0;
      end else begin
         cancel_pulse <= do_cancel;
         if (do_issue) begin
            flip_valid <= 1'b1;
            pair_q.i   <= h0;
            pair_q.j   <= h1;
         end else if (stage_free) begin
            // Command taken (or none pending) and nothing new to send.
            flip_valid <= 1'b0;
         end
      end
   end

   assign flip_i = pair_q.i;
   assign flip_j = pair_q.j;

   // ---------------------------------------------------------------------
   // Shadow word and sticky parity flag
   // ---------------------------------------------------------------------
   assign accept = flip_valid && flip_ready;

   always_comb begin
      shadow_next = shadow_q;
      if (accept) begin
         shadow_next = shadow_q
                     ^ (WORD_W'(1) << pair_q.i)
                     ^ (WORD_W'(1) << pair_q.j);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q   <= '0;
         parity_err <= 1'b0;
      end else begin
         shadow_q   <= shadow_next;
         parity_err <= parity_err | (^shadow_next);
      end
   end

   // ---------------------------------------------------------------------
   // Structural invariants
   // ---------------------------------------------------------------------
   a_pair_distinct : assert property (@(posedge clk) disable iff (!rst_n)
      flip_valid |-> (flip_i != flip_j));

   a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));

   a_parity_even : assert property (@(posedge clk) disable iff (!rst_n)
      !parity_err);

endmodule : flip_pair_sched
